sm_imem_loader: RTL and testbench

Instruction memory with a byte-stream program loader for the schoolMIPS CPU. It receives a framed program image over a byte handshake, typically from a UART receiver, writes it into an internal word array, and then releases the CPU from reset. Once loaded, it serves `imData` combinationally for the CPU's word address `imAddr`, so it sits directly upstream of the CPU's fetch port.

---
 rtl/sm_imem_loader.sv | 112 +++++++++++
 tb/tb_sm_imem_loader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_imem_loader.sv
// schoolMIPS instruction memory with a framed byte-stream program loader.
// Holds the CPU in reset until an image with a matching XOR checksum is loaded.
module sm_imem_loader #(
  parameter int AW      = 6,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_req,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [31:0] imAddr,
  output logic [31:0] imData,
  output logic        cpu_rst_n,
  output logic        busy,
  output logic        err
);
  localparam int DEPTH = 2 ** AW;
  localparam int CW    = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, CHK, RUN, ERR} state_t;

  state_t        state, nextState;
  logic [31:0]   mem [DEPTH];
  logic [7:0]    nHi;
  logic [AW:0]   nWords;
  logic [AW-1:0] wAddr;
  logic [1:0]    byteIdx;
  logic [23:0]   shiftReg;
  logic [7:0]    xorAcc;
  logic [CW-1:0] toutCnt;

  logic          loading, accept, lastWord, timedOut, countValid, wrEn;
  logic [15:0]   nFull;

  assign loading    = (state == HDR0) || (state == HDR1) || (state == DATA) || (state == CHK);
  assign accept     = rx_valid & loading;
  assign nFull      = {nHi, rx_data};
  assign countValid = (nFull != 16'd0) && ({1'b0, nFull} <= 17'(DEPTH));
  assign lastWord   = ({1'b0, wAddr} + (AW+1)'(1)) == nWords;
  assign timedOut   = toutCnt == CW'(TIMEOUT - 1);
  assign wrEn       = accept && !load_req && (state == DATA) && (byteIdx == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  // NOTE: nextState is given its default first so no path through the block leaves it unassigned (no latch).
  always_comb begin
    nextState = state;
    if (load_req) begin
      nextState = HDR0;
    end else if (accept) begin
      case (state)
        HDR0:    nextState = HDR1;
        HDR1:    nextState = countValid ? DATA : ERR;
        DATA:    if (byteIdx == 2'd3 && lastWord) nextState = CHK;
        CHK:     nextState = (rx_data == xorAcc) ? RUN : ERR;
        default: nextState = state;
      endcase
    end else if (loading && timedOut) begin
      nextState = ERR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nHi      <= '0;
      nWords   <= '0;
      wAddr    <= '0;
      byteIdx  <= '0;
      shiftReg <= '0;
      xorAcc   <= '0;
      toutCnt  <= '0;
    end else if (load_req) begin
      wAddr   <= '0;
      byteIdx <= '0;
      xorAcc  <= '0;
      toutCnt <= '0;
    end else begin
      if (accept)                     toutCnt <= '0;
      else if (loading && !timedOut)  toutCnt <= toutCnt + CW'(1);
      if (accept) begin
        case (state)
          HDR0: nHi    <= rx_data;
          HDR1: nWords <= nFull[AW:0];
          DATA: begin
            xorAcc  <= xorAcc ^ rx_data;
            byteIdx <= byteIdx + 2'd1;
            if (byteIdx == 2'd3) wAddr    <= wAddr + AW'(1);
            else                 shiftReg <= {shiftReg[15:0], rx_data};
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: the word array has no reset so it maps onto plain RAM; stale words survive reset and reloads.
  always_ff @(posedge clk) begin
    if (wrEn) mem[wAddr] <= {shiftReg, rx_data};
  end

  // Outputs decode the registered state only; reset drops cpu_rst_n without waiting for a clock.
  assign rx_ready  = loading;
  assign busy      = loading;
  assign err       = (state == ERR);
  assign cpu_rst_n = (state == RUN);
  assign imData    = (state == RUN) ? mem[imAddr[AW-1:0]] : 32'h0000_0000;
endmodule

// File: tb/tb_sm_imem_loader.sv
// Self-checking bench for sm_imem_loader: frame-level model of the loader
// plus a per-cycle compare of every output against that model.
module tb_sm_imem_loader;
  localparam int AW      = 6;
  localparam int DEPTH   = 64;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_req = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready, cpu_rst_n, busy, err;
  logic [31:0] imAddr, imData;

  sm_imem_loader #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .load_req(load_req), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .imAddr(imAddr), .imData(imData),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  bit          expBusy = 0, expErr = 0, expRun = 0;
  logic [31:0] modelMem   [DEPTH];
  bit          modelKnown [DEPTH];
  logic [31:0] frameWords [DEPTH];
  bit          useFixed = 0;
  logic [31:0] fixedAddr = 32'h0;
  int          maxGap = 3;
  logic [AW-1:0] cmpIdx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Per-cycle compare against the model, half a cycle away from the active edge.
  always @(negedge clk) begin
    imAddr = useFixed ? fixedAddr : $urandom;
    #1;
    check("busy", {31'b0, busy}, {31'b0, expBusy});
    check("rx_ready", {31'b0, rx_ready}, {31'b0, expBusy});
    check("err", {31'b0, err}, {31'b0, expErr});
    check("cpu_rst_n", {31'b0, cpu_rst_n}, {31'b0, expRun});
    cmpIdx = imAddr[AW-1:0];
    if (!expRun)                check("imData_nop", imData, 32'h0);
    else if (modelKnown[cmpIdx]) check("imData", imData, modelMem[cmpIdx]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b);
    rx_valid = 1'b0;
    repeat ($urandom_range(0, maxGap)) tick();
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic pulseLoad();
    load_req = 1'b1;
    rx_valid = 1'($urandom);
    rx_data  = 8'($urandom);
    tick();
    load_req = 1'b0;
    rx_valid = 1'b0;
    expBusy = 1; expErr = 0; expRun = 0;
  endtask

  task automatic peek(input logic [31:0] a, input logic [31:0] expv, input string name);
    fixedAddr = a;
    useFixed  = 1;
    @(negedge clk);
    #2;
    check(name, imData, expv);
    useFixed = 0;
  endtask

  // Sends a whole frame of n words from frameWords; chkSel < 0 sends the correct checksum.
  task automatic loadFrame(input int n, input bit doPulse, input int chkSel);
    logic [15:0] nv;
    logic [7:0]  x, b, chk;
    logic [31:0] w;
    nv = n[15:0];
    x  = 8'h00;
    if (doPulse) pulseLoad();
    sendByte(nv[15:8]);
    sendByte(nv[7:0]);
    if (n < 1 || n > DEPTH) begin
      expBusy = 0; expErr = 1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      w = frameWords[i];
      for (int k = 3; k >= 0; k--) begin
        b = w[8*k +: 8];
        x = x ^ b;
        sendByte(b);
      end
      modelMem[i]   = w;
      modelKnown[i] = 1;
    end
    chk = (chkSel < 0) ? x : chkSel[7:0];
    sendByte(chk);
    expBusy = 0;
    if (chk == x) expRun = 1;
    else          expErr = 1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) modelKnown[i] = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("reset_cpu_rst_n", {31'b0, cpu_rst_n}, 32'h0);
    check("reset_imData", imData, 32'h0);

    // Basic two-word load; the data bytes XOR to 8'h20.
    frameWords[0] = 32'h2401_0005;
    frameWords[1] = 32'h0000_0000;
    loadFrame(2, 1, 8'h20);
    check("basic_cpu_rst_n", {31'b0, cpu_rst_n}, 32'h1);
    peek(32'd0, 32'h2401_0005, "basic_w0");
    peek(32'd1, 32'h0, "basic_w1");
    peek(32'd64, 32'h2401_0005, "basic_alias");

    // Same frame with a wrong checksum.
    loadFrame(2, 1, 8'h22);
    check("bad_err", {31'b0, err}, 32'h1);
    check("bad_cpu_rst_n", {31'b0, cpu_rst_n}, 32'h0);
    peek(32'd0, 32'h0, "bad_nop");

    // Count bounds.
    loadFrame(0, 1, -1);
    check("n0_err", {31'b0, err}, 32'h1);
    loadFrame(65, 1, -1);
    check("n65_err", {31'b0, err}, 32'h1);
    for (int i = 0; i < DEPTH; i++) frameWords[i] = $urandom;
    frameWords[63] = 32'hDEAD_BEEF;
    maxGap = 0;
    loadFrame(64, 1, -1);
    check("n64_run", {31'b0, cpu_rst_n}, 32'h1);
    peek(32'd63, 32'hDEAD_BEEF, "n64_last");
    maxGap = 3;

    // Timeout: stall after the first data byte.
    pulseLoad();
    sendByte(8'h00);
    sendByte(8'h01);
    sendByte(8'h24);
    for (int k = 1; k <= TIMEOUT; k++) begin
      tick();
      if (k == TIMEOUT) begin
        expBusy = 0; expErr = 1;
      end else if (k == TIMEOUT - 1) begin
        check("timeout_not_yet", {31'b0, err}, 32'h0);
      end
    end
    check("timeout_err", {31'b0, err}, 32'h1);
    check("timeout_busy", {31'b0, busy}, 32'h0);

    // Restart colliding with a valid byte in DATA.
    pulseLoad();
    sendByte(8'h00);
    sendByte(8'h01);
    sendByte(8'h11);
    sendByte(8'h22);
    load_req = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h33;
    tick();
    load_req = 1'b0;
    rx_valid = 1'b0;
    frameWords[0] = 32'hCAFE_F00D;
    loadFrame(1, 0, -1);
    check("collide_run", {31'b0, cpu_rst_n}, 32'h1);
    peek(32'd0, 32'hCAFE_F00D, "collide_w0");

    // Reset in the middle of DATA: one word written, then a stray byte.
    pulseLoad();
    sendByte(8'h00);
    sendByte(8'h02);
    frameWords[0] = 32'h0BAD_F00D;
    for (int k = 3; k >= 0; k--) sendByte(frameWords[0][8*k +: 8]);
    modelMem[0] = frameWords[0];
    modelKnown[0] = 1;
    sendByte(8'h55);
    #2;
    rst_n = 1'b0;
    expBusy = 0; expErr = 0; expRun = 0;
    #1;
    check("midrst_cpu_rst_n", {31'b0, cpu_rst_n}, 32'h0);
    check("midrst_rx_ready", {31'b0, rx_ready}, 32'h0);
    rx_valid = 1'b1;
    rx_data  = 8'h00;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("midrst_idle", {31'b0, busy}, 32'h0);
    rx_valid = 1'b0;

    // Randomized frames: mostly valid, some bad counts and bad checksums.
    for (int f = 0; f < 14; f++) begin
      int n, sel, cs;
      maxGap = $urandom_range(0, 3);
      sel = $urandom_range(0, 9);
      if (sel == 0)      n = 0;
      else if (sel == 1) n = $urandom_range(65, 400);
      else               n = $urandom_range(1, 10);
      for (int i = 0; i < DEPTH; i++) if (i < n) frameWords[i] = $urandom;
      cs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : -1;
      loadFrame(n, 1, cs);
      repeat ($urandom_range(2, 6)) begin
        rx_valid = 1'($urandom);
        rx_data  = 8'($urandom);
        tick();
      end
      rx_valid = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
